// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types, widths and digit helper for the display sharing controller
//   NUM_SRC   number of display requesters
//   DIG_BLANK code that leaves a digit dark
//   state_t   arbiter state (ST_IDLE / ST_SHOW)
package disp_pkg;

    localparam int NUM_SRC = 3;
    localparam int NUM_DIG = 6;
    localparam int VAL_W   = 24;
    localparam int MASK_W  = 6;

    localparam logic [7:0] DIG_BLANK = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // Request bit of source s; out-of-range indices read as not requesting.
    function automatic logic req_bit(input logic [NUM_SRC-1:0] r, input logic [1:0] s);
        case (s)
            2'd0:    req_bit = r[0];
            2'd1:    req_bit = r[1];
            2'd2:    req_bit = r[2];
            default: req_bit = 1'b0;
        endcase
    endfunction

    // The other member of the round-robin pair {1, 2}.
    function automatic logic [1:0] other_src(input logic [1:0] s);
        other_src = (s == 2'd1) ? 2'd2 : 2'd1;
    endfunction

    function automatic logic [7:0] digit_code(input logic [3:0] nib, input logic blank,
                                              input logic blink, input logic phase);
        digit_code = (blank || (blink && phase)) ? DIG_BLANK : {4'h0, nib};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running millisecond tick generator
//   i_clk   system clock
//   i_rst   synchronous active-high reset
//   o_tick  one-cycle pulse every TICK_DIV+1 clocks (while the counter equals TICK_DIV)
module ms_tick_gen #(
    parameter logic [15:0] TICK_DIV = 16'd49999
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 16'd0;
        end else if (r_cnt == TICK_DIV) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_tick = (r_cnt == TICK_DIV);

endmodule

// File: rtl/disp_share_ctrl.sv
// rtl/disp_share_ctrl.sv - shares the six-digit display between an alarm source and two round-robin sources
//   clk, rst                 system clock, synchronous active-high reset
//   req                      level requests, req[0] preempts
//   src_val                  three 24-bit hex values, source k at [24k+23:24k]
//   src_blank / src_blink    per-digit masks, source k at [6k+5:6k], bit 5 = DIG1
//   ack                      one-cycle pulse on a new grant
//   active_valid, active_src current grant (src 0 when none)
//   data0..data5             digit codes DIG1..DIG6, 8'hFF when dark
module disp_share_ctrl
    import disp_pkg::*;
#(
    parameter logic [15:0] TICK_DIV = 16'd49999,
    parameter int unsigned DWELL_MS = 2000,
    parameter int unsigned BLINK_MS = 250
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          req,
    input  logic [NUM_SRC*VAL_W-1:0]    src_val,
    input  logic [NUM_SRC*MASK_W-1:0]   src_blank,
    input  logic [NUM_SRC*MASK_W-1:0]   src_blink,
    output logic [NUM_SRC-1:0]          ack,
    output logic                        active_valid,
    output logic [1:0]                  active_src,
    output logic [7:0]                  data0,
    output logic [7:0]                  data1,
    output logic [7:0]                  data2,
    output logic [7:0]                  data3,
    output logic [7:0]                  data4,
    output logic [7:0]                  data5
);

    localparam int DW = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
    localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_MS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_src, w_src_nxt;
    logic [1:0]           r_rr, w_rr_nxt;
    logic [DW-1:0]        r_dwell, w_dwell_nxt;
    logic [BW-1:0]        r_blink_cnt;
    logic                 r_blink_phase;
    logic [NUM_SRC-1:0]   r_ack, w_ack_nxt;
    logic                 r_valid;
    logic [7:0]           r_data [NUM_DIG];
    logic [7:0]           w_data_nxt [NUM_DIG];

    logic                 w_tick;
    logic                 w_expire;
    logic                 w_cur_req;
    logic                 w_other_req;
    logic                 w_arb;
    logic                 w_grant;
    logic [VAL_W-1:0]     w_sel_val;
    logic [MASK_W-1:0]    w_sel_blank;
    logic [MASK_W-1:0]    w_sel_blink;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_tick (w_tick)
    );

    assign w_cur_req   = req_bit(req, r_src);
    assign w_other_req = (r_src == 2'd0) ? 1'b0 : req_bit(req, other_src(r_src));
    // Expiry needs a tick while dwell is already 0, so a grant is held for
    // DWELL_MS ticks in total; source 0 is never rotated out on expiry.
    assign w_expire    = (r_state == ST_SHOW) && (r_src != 2'd0) && w_tick && (r_dwell == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_src         <= 2'd0;
            r_rr          <= 2'd1;
            r_dwell       <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_ack         <= '0;
            r_valid       <= 1'b0;
            for (int i = 0; i < NUM_DIG; i++) begin
                r_data[i] <= DIG_BLANK;
            end
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_rr    <= w_rr_nxt;
            r_dwell <= w_dwell_nxt;
            r_ack   <= w_ack_nxt;
            r_valid <= (w_state_nxt == ST_SHOW);
            for (int i = 0; i < NUM_DIG; i++) begin
                r_data[i] <= w_data_nxt[i];
            end
            if (w_tick) begin
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    // Next-state / arbitration
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_rr_nxt    = r_rr;
        w_grant     = 1'b0;
        w_dwell_nxt = (w_tick && (r_dwell != '0)) ? r_dwell - 1'b1 : r_dwell;
        w_arb       = 1'b0;

        case (r_state)
            ST_IDLE: w_arb = |req;
            ST_SHOW: w_arb = !w_cur_req
                          || (req[0] && (r_src != 2'd0))
                          || (w_expire && w_other_req);
            default: w_arb = 1'b0;
        endcase

        if (w_arb) begin
            if (req[0]) begin
                w_state_nxt = ST_SHOW;
                w_src_nxt   = 2'd0;
                w_grant     = 1'b1;
                w_dwell_nxt = DWELL_LOAD;
            end else if (req_bit(req, r_rr)) begin
                w_state_nxt = ST_SHOW;
                w_src_nxt   = r_rr;
                w_rr_nxt    = other_src(r_rr);
                w_grant     = 1'b1;
                w_dwell_nxt = DWELL_LOAD;
            end else if (req_bit(req, other_src(r_rr))) begin
                w_state_nxt = ST_SHOW;
                w_src_nxt   = other_src(r_rr);
                w_rr_nxt    = r_rr;
                w_grant     = 1'b1;
                w_dwell_nxt = DWELL_LOAD;
            end else begin
                w_state_nxt = ST_IDLE;
                w_src_nxt   = 2'd0;
                w_dwell_nxt = '0;
            end
        end else if (w_expire) begin
            // Expired with nobody waiting: keep showing, start a fresh dwell.
            w_dwell_nxt = DWELL_LOAD;
        end
    end

    // Output next values (registered above)
    always_comb begin
        w_ack_nxt   = w_grant ? (NUM_SRC'(1) << w_src_nxt) : '0;
        w_sel_val   = src_val[VAL_W-1:0];
        w_sel_blank = src_blank[MASK_W-1:0];
        w_sel_blink = src_blink[MASK_W-1:0];
        case (w_src_nxt)
            2'd1: begin
                w_sel_val   = src_val[2*VAL_W-1:VAL_W];
                w_sel_blank = src_blank[2*MASK_W-1:MASK_W];
                w_sel_blink = src_blink[2*MASK_W-1:MASK_W];
            end
            2'd2: begin
                w_sel_val   = src_val[3*VAL_W-1:2*VAL_W];
                w_sel_blank = src_blank[3*MASK_W-1:2*MASK_W];
                w_sel_blink = src_blink[3*MASK_W-1:2*MASK_W];
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_DIG; i++) begin
            w_data_nxt[i] = DIG_BLANK;
            if (w_state_nxt == ST_SHOW) begin
                w_data_nxt[i] = digit_code(w_sel_val[VAL_W-1-4*i -: 4],
                                           w_sel_blank[MASK_W-1-i],
                                           w_sel_blink[MASK_W-1-i],
                                           r_blink_phase);
            end
        end
    end

    assign ack          = r_ack;
    assign active_valid = r_valid;
    assign active_src   = r_src;
    assign data0        = r_data[0];
    assign data1        = r_data[1];
    assign data2        = r_data[2];
    assign data3        = r_data[3];
    assign data4        = r_data[4];
    assign data5        = r_data[5];

endmodule

// File: tb/tb_disp_share_ctrl.sv
// tb/tb_disp_share_ctrl.sv - directed self-checking bench for disp_share_ctrl
module tb_disp_share_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [71:0] src_val;
    logic [17:0] src_blank;
    logic [17:0] src_blink;
    logic [2:0]  ack;
    logic        active_valid;
    logic [1:0]  active_src;
    logic [7:0]  data0, data1, data2, data3, data4, data5;
    logic [47:0] data_all;

    int n_tests;
    int n_fail;

    // 5-cycle ms tick, 4-tick dwell (20 cycles), 1-tick blink half-period (5 cycles)
    disp_share_ctrl #(
        .TICK_DIV (16'd4),
        .DWELL_MS (4),
        .BLINK_MS (1)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .src_val      (src_val),
        .src_blank    (src_blank),
        .src_blink    (src_blink),
        .ack          (ack),
        .active_valid (active_valid),
        .active_src   (active_src),
        .data0        (data0),
        .data1        (data1),
        .data2        (data2),
        .data3        (data3),
        .data4        (data4),
        .data5        (data5)
    );

    assign data_all = {data0, data1, data2, data3, data4, data5};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        src_val   = 72'h0;
        src_blank = 18'h0;
        src_blink = 18'h0;
        do_reset();
        n_tests = n_tests + 1;
        if (data_all !== {6{8'hFF}}) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_data: got %h want %h", data_all, {6{8'hFF}});
        end
        n_tests = n_tests + 1;
        if (active_valid !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_valid: got %b want 0", active_valid);
        end
        n_tests = n_tests + 1;
        if (ack !== 3'b000) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_ack: got %b want 000", ack);
        end
        n_tests = n_tests + 1;
        if (active_src !== 2'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_src: got %0d want 0", active_src);
        end
    endtask

    task automatic test_grant();
        src_val   = {24'h0, 24'h12AB9F, 24'h0};
        src_blank = 18'h0;
        src_blink = 18'h0;
        do_reset();
        req = 3'b010;
        step();
        n_tests = n_tests + 1;
        if (ack !== 3'b010) begin
            n_fail = n_fail + 1;
            $display("FAIL grant_ack: got %b want 010", ack);
        end
        n_tests = n_tests + 1;
        if (active_src !== 2'd1 || active_valid !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL grant_src: got src %0d valid %b want src 1 valid 1", active_src, active_valid);
        end
        n_tests = n_tests + 1;
        if (data_all !== 48'h01020A0B090F) begin
            n_fail = n_fail + 1;
            $display("FAIL grant_data: got %h want 01020a0b090f", data_all);
        end
        step();
        n_tests = n_tests + 1;
        if (ack !== 3'b000) begin
            n_fail = n_fail + 1;
            $display("FAIL grant_ack_pulse: got %b want 000", ack);
        end
    endtask

    task automatic test_rotate_preempt();
        src_val   = {24'h222222, 24'h111111, 24'hABCDEF};
        src_blank = 18'h0;
        src_blink = 18'h0;
        do_reset();
        req = 3'b110;
        step();                                   // E1: rr=1 wins
        n_tests = n_tests + 1;
        if (active_src !== 2'd1 || ack !== 3'b010) begin
            n_fail = n_fail + 1;
            $display("FAIL rot_first: got src %0d ack %b want src 1 ack 010", active_src, ack);
        end
        for (int k = 2; k <= 19; k++) step();     // E19
        n_tests = n_tests + 1;
        if (active_src !== 2'd1) begin
            n_fail = n_fail + 1;
            $display("FAIL rot_hold1: got src %0d want 1", active_src);
        end
        step();                                   // E20
        n_tests = n_tests + 1;
        if (active_src !== 2'd2 || ack !== 3'b100) begin
            n_fail = n_fail + 1;
            $display("FAIL rot_to2: got src %0d ack %b want src 2 ack 100", active_src, ack);
        end
        n_tests = n_tests + 1;
        if (data_all !== 48'h020202020202) begin
            n_fail = n_fail + 1;
            $display("FAIL rot_data2: got %h want 020202020202", data_all);
        end
        for (int k = 21; k <= 39; k++) step();    // E39
        n_tests = n_tests + 1;
        if (active_src !== 2'd2) begin
            n_fail = n_fail + 1;
            $display("FAIL rot_hold2: got src %0d want 2", active_src);
        end
        step();                                   // E40
        n_tests = n_tests + 1;
        if (active_src !== 2'd1 || ack !== 3'b010) begin
            n_fail = n_fail + 1;
            $display("FAIL rot_to1: got src %0d ack %b want src 1 ack 010", active_src, ack);
        end
        req = 3'b111;
        step();
        n_tests = n_tests + 1;
        if (active_src !== 2'd0 || ack !== 3'b001) begin
            n_fail = n_fail + 1;
            $display("FAIL preempt: got src %0d ack %b want src 0 ack 001", active_src, ack);
        end
        n_tests = n_tests + 1;
        if (data_all !== 48'h0A0B0C0D0E0F) begin
            n_fail = n_fail + 1;
            $display("FAIL preempt_data: got %h want 0a0b0c0d0e0f", data_all);
        end
        for (int k = 0; k < 30; k++) step();
        n_tests = n_tests + 1;
        if (active_src !== 2'd0 || active_valid !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL src0_sticky: got src %0d valid %b want src 0 valid 1", active_src, active_valid);
        end
    endtask

    task automatic test_blank_blink();
        logic [7:0] exp5;
        src_val   = {24'h0, 24'h123456, 24'h0};
        src_blank = {6'b000000, 6'b100000, 6'b000000};
        src_blink = {6'b000000, 6'b000001, 6'b000000};
        do_reset();
        req = 3'b010;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp5 = (((k - 1) / 5) % 2 == 1) ? 8'hFF : 8'h06;
            n_tests = n_tests + 1;
            if (data0 !== 8'hFF) begin
                n_fail = n_fail + 1;
                $display("FAIL blank_dig1 edge %0d: got %h want ff", k, data0);
            end
            n_tests = n_tests + 1;
            if (data5 !== exp5) begin
                n_fail = n_fail + 1;
                $display("FAIL blink_dig6 edge %0d: got %h want %h", k, data5, exp5);
            end
            if (k == 1) begin
                n_tests = n_tests + 1;
                if ({data1, data2, data3, data4} !== 32'h02030405) begin
                    n_fail = n_fail + 1;
                    $display("FAIL blink_mid_digits: got %h want 02030405", {data1, data2, data3, data4});
                end
            end
        end
    endtask

    task automatic test_drop();
        src_val   = {24'h999999, 24'h555555, 24'h0};
        src_blank = 18'h0;
        src_blink = 18'h0;
        do_reset();
        req = 3'b100;
        step();
        n_tests = n_tests + 1;
        if (active_src !== 2'd2 || ack !== 3'b100) begin
            n_fail = n_fail + 1;
            $display("FAIL drop_grant2: got src %0d ack %b want src 2 ack 100", active_src, ack);
        end
        req = 3'b110;
        step();
        req = 3'b010;
        step();
        n_tests = n_tests + 1;
        if (active_src !== 2'd1 || ack !== 3'b010) begin
            n_fail = n_fail + 1;
            $display("FAIL drop_to1: got src %0d ack %b want src 1 ack 010", active_src, ack);
        end
        req = 3'b000;
        step();
        n_tests = n_tests + 1;
        if (active_valid !== 1'b0 || active_src !== 2'd0 || ack !== 3'b000) begin
            n_fail = n_fail + 1;
            $display("FAIL drop_idle: got valid %b src %0d ack %b want 0 0 000", active_valid, active_src, ack);
        end
        n_tests = n_tests + 1;
        if (data_all !== {6{8'hFF}}) begin
            n_fail = n_fail + 1;
            $display("FAIL drop_idle_data: got %h want all ff", data_all);
        end
    endtask

    task automatic test_back_to_back_reset();
        src_val   = {24'h0, 24'h654321, 24'h0};
        src_blank = 18'h0;
        src_blink = 18'h0;
        do_reset();
        req = 3'b010;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        n_tests = n_tests + 1;
        if (active_valid !== 1'b0 || ack !== 3'b000 || active_src !== 2'd0 || data_all !== {6{8'hFF}}) begin
            n_fail = n_fail + 1;
            $display("FAIL rst_mid_show: got valid %b ack %b src %0d data %h want reset values",
                     active_valid, ack, active_src, data_all);
        end
        rst = 1'b0;
        step();
        n_tests = n_tests + 1;
        if (active_valid !== 1'b1 || ack !== 3'b010 || active_src !== 2'd1) begin
            n_fail = n_fail + 1;
            $display("FAIL rst_regrant: got valid %b ack %b src %0d want 1 010 1", active_valid, ack, active_src);
        end
        n_tests = n_tests + 1;
        if (data_all !== 48'h060504030201) begin
            n_fail = n_fail + 1;
            $display("FAIL rst_regrant_data: got %h want 060504030201", data_all);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req       = 3'b000;
        src_val   = 72'h0;
        src_blank = 18'h0;
        src_blink = 18'h0;
        test_reset();
        test_grant();
        test_rotate_preempt();
        test_blank_blink();
        test_drop();
        test_back_to_back_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
